// File: rtl/wb_slave_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_slave_decoder : one-outstanding Wishbone decoder, 4 slaves at 0x3000_0000 |
// | Optional WB_DECODER_TIMEOUT_EN: error out a silent slave. Revision 1.0       |
// +----------------------------------------------------------------------------+
module wb_slave_decoder #(
   parameter int BITS           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic [BITS-1:0]   m_adr_i,
   input  logic [BITS-1:0]   m_dat_i,
   output logic [BITS-1:0]   m_dat_o,
   input  logic              m_we_i,
   input  logic [3:0]        m_sel_i,
   input  logic              m_cyc_i,
   input  logic              m_stb_i,
   output logic              m_ack_o,
   output logic              m_err_o,
   output logic [BITS-1:0]   s_adr_o,
   output logic [BITS-1:0]   s_dat_o,
   output logic              s_we_o,
   output logic [3:0]        s_sel_o,
   output logic [3:0]        s_cyc_o,
   output logic [3:0]        s_stb_o,
   input  logic [4*BITS-1:0] s_dat_i,
   input  logic [3:0]        s_ack_i,
   input  logic [3:0]        s_err_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      slot_q, slot_d;
   logic [3:0]      strobe_q, strobe_d;
   logic [BITS-1:0] adr_q, adr_d;
   logic [BITS-1:0] wdat_q, wdat_d;
   logic            we_q, we_d;
   logic [3:0]      sel_q, sel_d;
   logic [BITS-1:0] rdat_q, rdat_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
`ifdef WB_DECODER_TIMEOUT_EN
   logic [15:0]     cnt_q, cnt_d;
`endif

   logic            mapped;
   logic            slave_ack;
   logic            slave_err;
   logic [BITS-1:0] slave_rdata;

   assign mapped    = (m_adr_i[31:18] == 14'h0C00);
   assign slave_ack = s_ack_i[slot_q];
   assign slave_err = s_err_i[slot_q];

   always_comb begin
      slave_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (slot_q == i[1:0]) slave_rdata = s_dat_i[i*BITS +: BITS];
      end
   end

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      strobe_d = strobe_q;
      adr_d    = adr_q;
      wdat_d   = wdat_q;
      we_d     = we_q;
      sel_d    = sel_q;
      rdat_d   = rdat_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
`ifdef WB_DECODER_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               adr_d  = m_adr_i;
               wdat_d = m_dat_i;
               we_d   = m_we_i;
               sel_d  = m_sel_i;
               slot_d = m_adr_i[17:16];
               if (mapped) begin
                  strobe_d = 4'b0001 << m_adr_i[17:16];
                  state_d  = ACTIVE;
`ifdef WB_DECODER_TIMEOUT_EN
                  cnt_d    = 16'd0;
`endif
               end else begin
                  err_d   = 1'b1;
                  rdat_d  = '0;
                  state_d = RESP;
               end
            end
         end
         ACTIVE: begin
            // Abort beats any slave response arriving in the same cycle.
            if (!m_cyc_i) begin
               strobe_d = 4'b0000;
               state_d  = IDLE;
            end else if (slave_err) begin
               strobe_d = 4'b0000;
               err_d    = 1'b1;
               rdat_d   = '0;
               state_d  = RESP;
            end else if (slave_ack) begin
               strobe_d = 4'b0000;
               ack_d    = 1'b1;
               rdat_d   = we_q ? '0 : slave_rdata;
               state_d  = RESP;
`ifdef WB_DECODER_TIMEOUT_EN
            end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
               strobe_d = 4'b0000;
               err_d    = 1'b1;
               rdat_d   = '0;
               state_d  = RESP;
            end else begin
               cnt_d    = cnt_q + 16'd1;
`endif
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q  <= IDLE;
         slot_q   <= 2'd0;
         strobe_q <= 4'b0000;
         adr_q    <= '0;
         wdat_q   <= '0;
         we_q     <= 1'b0;
         sel_q    <= 4'b0000;
         rdat_q   <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
`ifdef WB_DECODER_TIMEOUT_EN
         cnt_q    <= 16'd0;
`endif
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         strobe_q <= strobe_d;
         adr_q    <= adr_d;
         wdat_q   <= wdat_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         rdat_q   <= rdat_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
`ifdef WB_DECODER_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign m_dat_o = rdat_q;
   assign m_ack_o = ack_q;
   assign m_err_o = err_q;
   assign s_adr_o = adr_q;
   assign s_dat_o = wdat_q;
   assign s_we_o  = we_q;
   assign s_sel_o = sel_q;
   assign s_cyc_o = strobe_q;
   assign s_stb_o = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_decoder.sv
`default_nettype none
// Scoreboarded bench for wb_slave_decoder: driver/slave model push expected
// responses, an independent monitor pops and compares them.
module tb_wb_slave_decoder;
   localparam int BITS = 32;
   localparam int TO   = 8;
`ifdef WB_DECODER_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif
   localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_SILENT = 3, M_ABORT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   m_adr = '0, m_dat_w = '0;
   logic [31:0]   m_dat_r;
   logic          m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
   logic [3:0]    m_sel = '0;
   logic          m_ack, m_err;
   logic [31:0]   s_adr, s_dat_w;
   logic          s_we;
   logic [3:0]    s_sel, s_cyc, s_stb;
   logic [127:0]  s_dat_r = '0;
   logic [3:0]    s_ack = '0, s_err = '0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      bit          err;
      logic [31:0] data;
      int          edge_n;
   } exp_t;
   exp_t        q[$];
   logic [31:0] last_dat = '0;

   wb_slave_decoder #(.BITS(BITS), .TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_dat_o(m_dat_r), .m_we_i(m_we),
      .m_sel_i(m_sel), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_ack_o(m_ack), .m_err_o(m_err),
      .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_we_o(s_we), .s_sel_o(s_sel),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb),
      .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: every output-response cycle must match the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         chk("stb_onehot", 32'($countones(s_stb) <= 1), 32'd1);
         chk("cyc_eq_stb", {28'd0, s_cyc}, {28'd0, s_stb});
         if (m_ack || m_err) begin
            chk("ack_err_exclusive", {31'd0, m_ack & m_err}, 32'd0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_response: ack=%0b err=%0b at cycle %0d, expected none",
                        m_ack, m_err, cyc);
            end else begin
               e = q.pop_front();
               chk("resp_err", {31'd0, m_err}, {31'd0, e.err});
               chk("resp_ack", {31'd0, m_ack}, {31'd0, !e.err});
               chk("resp_data", m_dat_r, e.data);
               chk("resp_cycle", cyc, e.edge_n);
            end
         end
      end
   end

   // Master + slave model for one transfer; k = strobe cycle in which the slave responds.
   task automatic do_xfer(input logic [31:0] adr, input logic [31:0] dat, input bit we,
                          input logic [3:0] sel, input int mode, input int k,
                          input logic [31:0] rdat);
      int   a, n, ncyc;
      bit   mapped, abort, got;
      exp_t e;
      logic [3:0] na, ne, onehot;
      @(negedge clk);
      chk("m_dat_hold", m_dat_r, last_dat);
      for (int i = 0; i < 4; i++) s_dat_r[i*32 +: 32] = $urandom;
      mapped = (adr[31:18] == 14'h0C00);
      n      = int'(adr[17:16]);
      onehot = 4'b0001 << n;
      if (mapped) s_dat_r[n*32 +: 32] = rdat;
      m_adr = adr; m_dat_w = dat; m_we = we; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
      a = cyc + 1;
      abort = mapped && ((mode == M_ABORT) || (mode == M_SILENT && !TIMEOUT_ON));
      ncyc  = (mode == M_SILENT) ? (TIMEOUT_ON ? TO : 12) : k;
      e.err = 1'b1; e.data = '0; e.edge_n = a;
      if (mapped) begin
         if (mode == M_ACK) begin
            e.err = 1'b0; e.data = we ? 32'd0 : rdat; e.edge_n = a + k;
         end else begin
            e.edge_n = a + ncyc;
         end
      end
      if (!abort) begin
         q.push_back(e);
         last_dat = e.data;
      end
      @(negedge clk);
      if (!mapped) begin
         chk("unmapped_no_stb", {28'd0, s_stb}, 32'd0);
      end else begin
         chk("s_adr", s_adr, adr);
         chk("s_dat", s_dat_w, dat);
         chk("s_we", {31'd0, s_we}, {31'd0, we});
         chk("s_sel", {28'd0, s_sel}, {28'd0, sel});
         for (int j = 1; j <= ncyc; j++) begin
            chk("s_stb_sel", {28'd0, s_stb}, {28'd0, onehot});
            na = 4'($urandom) & ~onehot;
            ne = 4'($urandom) & ~onehot;
            if (j == k && (mode == M_ACK || mode == M_ERR || mode == M_BOTH)) begin
               if (mode != M_ERR) na = na | onehot;
               if (mode != M_ACK) ne = ne | onehot;
            end
            s_ack = na; s_err = ne;
            @(negedge clk);
         end
      end
      if (abort) begin
         m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; s_err = '0;
         @(negedge clk);
         chk("abort_stb_clear", {28'd0, s_stb}, 32'd0);
         return;
      end
      s_ack = 4'($urandom); s_err = 4'($urandom);
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
         if (m_ack || m_err) got = 1'b1;
         else @(negedge clk);
      end
      chk("resp_seen", {31'd0, got}, 32'd1);
      chk("stb_after_resp", {28'd0, s_stb}, 32'd0);
      m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; s_err = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] adr;
      int mode, r;
      repeat (3) @(negedge clk);
      chk("rst_m_ack", {31'd0, m_ack}, 32'd0);
      chk("rst_m_err", {31'd0, m_err}, 32'd0);
      chk("rst_s_stb", {28'd0, s_stb}, 32'd0);
      chk("rst_m_dat", m_dat_r, 32'd0);
      chk("rst_s_adr", s_adr, 32'd0);
      rst_n = 1'b1;

      do_xfer(32'h3002_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, M_ACK, 3, 32'h0);
      do_xfer(32'h3001_0004, 32'h0, 1'b0, 4'hF, M_ACK, 2, 32'h0000_1234);
      do_xfer(32'h4000_0000, 32'h5555_AAAA, 1'b0, 4'hF, M_ACK, 1, 32'h0);
      do_xfer(32'h3001_0008, 32'h0, 1'b0, 4'hF, M_ACK, 1, 32'hCAFE_0001);
      do_xfer(32'h3003_0000, 32'h0, 1'b0, 4'hF, M_SILENT, 0, 32'h0);
      do_xfer(32'h3003_0004, 32'h0, 1'b0, 4'hF, M_ACK, TO, 32'h0BAD_F00D);
      do_xfer(32'h3000_0000, 32'h0, 1'b0, 4'h3, M_BOTH, 2, 32'h1111_2222);
      do_xfer(32'h3000_0010, 32'h0, 1'b0, 4'hF, M_ACK, 1, 32'h7777_8888);
      do_xfer(32'h3002_0000, 32'h0, 1'b0, 4'hF, M_ABORT, 3, 32'h0);
      do_xfer(32'h3002_0000, 32'h0, 1'b0, 4'hF, M_ERR, 4, 32'h0);
      do_xfer(32'h3001_0000, 32'h0, 1'b0, 4'hF, M_ACK, 1, 32'hA5A5_0F0F);

      // Reset asserted while a slave is strobed: everything clears at once.
      @(negedge clk);
      m_adr = 32'h3003_0020; m_dat_w = 32'h1357_9BDF; m_we = 1'b1; m_sel = 4'hC;
      m_cyc = 1'b1; m_stb = 1'b1;
      @(negedge clk);
      chk("pre_rst_stb", {28'd0, s_stb}, 32'h8);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_s_stb", {28'd0, s_stb}, 32'd0);
      chk("arst_s_cyc", {28'd0, s_cyc}, 32'd0);
      chk("arst_s_adr", s_adr, 32'd0);
      chk("arst_s_dat", s_dat_w, 32'd0);
      chk("arst_s_we", {31'd0, s_we}, 32'd0);
      chk("arst_s_sel", {28'd0, s_sel}, 32'd0);
      chk("arst_m_dat", m_dat_r, 32'd0);
      chk("arst_m_ack_err", {30'd0, m_ack, m_err}, 32'd0);
      m_cyc = 1'b0; m_stb = 1'b0;
      last_dat = '0;
      @(negedge clk);
      rst_n = 1'b1;
      do_xfer(32'h3003_0020, 32'h0, 1'b0, 4'hF, M_ACK, 2, 32'h2468_ACE0);

      for (int t = 0; t < 40; t++) begin
         r = int'($urandom_range(0, 99));
         if (r < 75) begin
            adr = {14'h0C00, 2'($urandom), 16'($urandom)};
         end else begin
            adr = $urandom;
            while (adr[31:18] == 14'h0C00) adr = $urandom;
         end
         r = int'($urandom_range(0, 99));
         mode = (r < 65) ? M_ACK : (r < 78) ? M_ERR : (r < 90) ? M_BOTH : M_ABORT;
         do_xfer(adr, $urandom, 1'($urandom), 4'($urandom), mode,
                 int'($urandom_range(1, 5)), $urandom);
      end

      repeat (4) @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/wb_slave_decoder.md
WB_SLAVE_DECODER -- requirements
Module: wb_slave_decoder

Interface
REQ-001 Parameter BITS, default 32, Wishbone address/data width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, slave-response timeout in clock cycles (range 2..65535).
REQ-003 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 wb_rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 m_adr_i  input  BITS  master address.
REQ-006 m_dat_i  input  BITS  master write data.
REQ-007 m_dat_o  output  BITS  read data returned to master.
REQ-008 m_we_i  input  1  write enable.
REQ-009 m_sel_i  input  4  byte selects.
REQ-010 m_cyc_i, m_stb_i  input  1 each  cycle and strobe.
REQ-011 m_ack_o, m_err_o  output  1 each  transfer completion and error.
REQ-012 s_adr_o, s_dat_o  output  BITS each  registered address and write data, broadcast to all slaves.
REQ-013 s_we_o, s_sel_o  output  1, 4  registered write enable and byte selects, broadcast.
REQ-014 s_cyc_o, s_stb_o  output  4 each  per-slave cycle and strobe, bit n = slave n.
REQ-015 s_dat_i  input  4*BITS  slave read data, slave n at bits [n*BITS +: BITS].
REQ-016 s_ack_i, s_err_i  input  4 each  per-slave ack and error.

Function
REQ-017 Decode: slave n = m_adr_i[17:16] selected when m_adr_i[31:18] == 14'h0C00 (0x3000_0000 + n*0x1_0000); any other address is unmapped.
REQ-018 FSM states: IDLE, ACTIVE, RESP; at most one transfer outstanding.
REQ-019 IDLE: on m_cyc_i & m_stb_i, register adr/dat/we/sel onto s_* outputs; mapped -> ACTIVE with s_cyc_o[n]=s_stb_o[n]=1 from next cycle; unmapped -> RESP with error, no slave strobed.
REQ-020 ACTIVE: on s_ack_i[n], capture s_dat_i slice n into m_dat_o, drop s_cyc_o/s_stb_o, go RESP (ack); on s_err_i[n], go RESP (error); both asserted together -> error.
REQ-021 RESP: m_ack_o or m_err_o high for exactly one cycle, then IDLE; never both high.
REQ-022 Latency: mapped transfer acks master one cycle after slave ack; unmapped errors in the cycle after strobe acceptance.
REQ-023 m_dat_o is 0 on error and write responses; it holds captured data until the next response.
REQ-024 Master drops m_cyc_i during ACTIVE: abort, clear s_cyc_o/s_stb_o next edge, IDLE, no ack/err issued.
REQ-025 s_ack_i/s_err_i bits of non-selected slaves, and any ack outside ACTIVE, are ignored.
REQ-026 Only one s_stb_o bit may be high at any time.

Reset
REQ-027 Asserted wb_rst_n_i: FSM -> IDLE; m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o = 0; m_dat_o, s_adr_o, s_dat_o, s_sel_o = 0; timeout counter = 0.
REQ-028 Reset asserted mid-transfer abandons the transfer with no response; first transfer is accepted on the first edge after deassertion.

Configuration
REQ-029 WB_DECODER_TIMEOUT_EN defined: a 16-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle; when it reaches TIMEOUT_CYCLES-1 with no slave ack/err, drop slave strobes and go RESP with error; a slave ack in that same cycle wins.
REQ-030 WB_DECODER_TIMEOUT_EN undefined: no counter; ACTIVE waits indefinitely for ack, err, or master abort.

Verification
REQ-031 Write 0x3002_0010 = 0xDEAD_BEEF, slave 2 acks after 3 cycles -> only s_stb_o[2] high, s_dat_o=0xDEADBEEF, m_ack_o one cycle after s_ack_i[2].
REQ-032 Read 0x3001_0004, slave 1 returns 0x0000_1234 -> m_dat_o=0x1234 with single-cycle m_ack_o.
REQ-033 Access 0x4000_0000 -> no s_stb_o, m_err_o high 1 cycle after strobe, m_dat_o=0.
REQ-034 TIMEOUT_CYCLES=8, timeout enabled, slave 3 silent -> m_err_o after 8 ACTIVE cycles, s_stb_o[3] cleared; repeat with ack on 8th cycle -> m_ack_o, no err.
REQ-035 Slave 0 asserts s_ack_i and s_err_i together -> m_err_o only; master drops m_cyc_i in ACTIVE -> no response, IDLE.
REQ-036 wb_rst_n_i low during ACTIVE -> all outputs 0 asynchronously; next transfer after release completes normally.
